// File: rtl/wr_data_fsm_if.sv
// Header, payload, AXI W and AXI B signals of the MWr data stage.
// master = the data stage itself, slave = its environment (demux + AXI slave).
interface wr_data_fsm_if #(
  parameter int DATA_WIDTH = 256
);
  logic                    hdr_wren;
  logic [127:0]            hdr_data;
  logic                    hdr_busy;
  logic                    pld_valid;
  logic [DATA_WIDTH-1:0]   pld_data;
  logic                    pld_ready;
  logic                    wvalid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wready;
  logic                    bvalid;
  logic [1:0]              bresp;
  logic                    bready;

  modport master (
    input  hdr_wren, hdr_data, pld_valid, pld_data, wready, bvalid, bresp,
    output hdr_busy, pld_ready, wvalid, wdata, wstrb, wlast, bready
  );

  modport slave (
    output hdr_wren, hdr_data, pld_valid, pld_data, wready, bvalid, bresp,
    input  hdr_busy, pld_ready, wvalid, wdata, wstrb, wlast, bready
  );
endinterface

// File: rtl/wr_data_fsm.sv
// MWr data stage: forwards payload beats onto AXI W with strobes derived from the TLP
// header and tracks outstanding B responses. WR_DATA_BRESP_ERR_EN adds err_cnt/err_flag.
module wr_data_lane_strb #(
  parameter int LANE  = 0,
  parameter int LANES = 8,
  parameter int OFF_W = 3
) (
  input  logic             active,
  input  logic [7:0]       beat_cnt,
  input  logic [OFF_W-1:0] off,
  input  logic [10:0]      len,
  input  logic [3:0]       first_be,
  input  logic [3:0]       last_be,
  output logic [3:0]       strb
);
  logic [11:0] g, lo, hi;

  // g is the DW index of this lane within the burst; [lo, hi) is the written range
  assign g  = 12'(beat_cnt) * 12'(LANES) + 12'(LANE);
  assign lo = 12'(off);
  assign hi = lo + 12'(len);

  always_comb begin
    strb = 4'h0;
    if (active && g >= lo && g < hi) begin
      if (g == lo)                              strb = first_be;
      else if (g == hi - 12'd1 && len > 11'd1)  strb = last_be;
      else                                      strb = 4'hF;
    end
  end
endmodule

module wr_data_fsm #(
  parameter int DATA_WIDTH      = 256,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  wr_data_fsm_if.master                        bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
`ifdef WR_DATA_BRESP_ERR_EN
  ,
  output logic [15:0]                          err_cnt,
  output logic                                 err_flag
`endif
);
  localparam int LANES = DATA_WIDTH / 32;
  localparam int OFF_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, DATA} state_t;

  state_t           state, state_d;
  logic [7:0]       beat_cnt, beats_q;
  logic [OFF_W-1:0] off_q;
  logic [10:0]      len_q;
  logic [3:0]       fbe_q, lbe_q;
  logic             busy, hdr_acc, w_hs, last_hs, b_hs;

  logic [10:0]      hdr_len;
  logic [OFF_W-1:0] hdr_off;
  logic [11:0]      hdr_span;
  logic [7:0]       hdr_beats;
  logic             unused_bits;

  assign hdr_len = (bus.hdr_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, bus.hdr_data[9:0]};
  assign hdr_off = (LANES == 1)       ? '0 :
                   bus.hdr_data[29]   ? bus.hdr_data[98 +: OFF_W] : bus.hdr_data[66 +: OFF_W];
  assign hdr_span  = 12'(hdr_off) + 12'(hdr_len) + 12'(LANES - 1);
  assign hdr_beats = 8'(hdr_span >> $clog2(LANES));
  assign unused_bits = ^{bus.hdr_data, bus.bresp};

  assign busy     = (state != IDLE) || (outstanding == OW'(MAX_OUTSTANDING));
  assign b_hs     = bus.bvalid && bus.bready;
  assign bus.bready = (outstanding != '0);

  always_comb begin
    state_d       = state;
    hdr_acc       = 1'b0;
    w_hs          = 1'b0;
    last_hs       = 1'b0;
    bus.hdr_busy  = busy;
    bus.wvalid    = 1'b0;
    bus.pld_ready = 1'b0;
    bus.wlast     = 1'b0;
    bus.wdata     = '0;
    case (state)
      IDLE: begin
        if (bus.hdr_wren && !busy) begin
          hdr_acc = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        bus.wvalid    = bus.pld_valid;
        bus.pld_ready = bus.wready;
        bus.wdata     = bus.pld_data;
        bus.wlast     = (beat_cnt == beats_q - 8'd1);
        w_hs          = bus.pld_valid && bus.wready;
        if (w_hs && bus.wlast) begin
          last_hs = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [LANES-1:0][3:0] lane_strb;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    wr_data_lane_strb #(.LANE(i), .LANES(LANES), .OFF_W(OFF_W)) u_strb (
      .active   (state == DATA),
      .beat_cnt (beat_cnt),
      .off      (off_q),
      .len      (len_q),
      .first_be (fbe_q),
      .last_be  (lbe_q),
      .strb     (lane_strb[i])
    );
  end

  assign bus.wstrb = lane_strb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      beats_q     <= '0;
      off_q       <= '0;
      len_q       <= '0;
      fbe_q       <= '0;
      lbe_q       <= '0;
      outstanding <= '0;
    end else begin
      state <= state_d;
      if (hdr_acc) begin
        beat_cnt <= '0;
        beats_q  <= hdr_beats;
        off_q    <= hdr_off;
        len_q    <= hdr_len;
        fbe_q    <= bus.hdr_data[35:32];
        lbe_q    <= bus.hdr_data[39:36];
      end else if (w_hs) begin
        beat_cnt <= last_hs ? 8'd0 : beat_cnt + 8'd1;
      end
      // a burst completing and a response retiring in the same cycle cancel out
      if (last_hs && !b_hs)      outstanding <= outstanding + OW'(1);
      else if (!last_hs && b_hs) outstanding <= outstanding - OW'(1);
    end
  end

`ifdef WR_DATA_BRESP_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (b_hs && bus.bresp != 2'b00) begin
      err_flag <= 1'b1;
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wr_data_fsm.sv
// Randomized bench for wr_data_fsm: a queue-based model predicts strobes, last and
// outstanding count from the header rules; directed scenarios pin literal values.
`timescale 1ns/1ps
module tb_wr_data_fsm;
  localparam int DW = 256, LANES = 8, MAXO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wr_data_fsm_if #(.DATA_WIDTH(DW)) bus ();
  logic [3:0] outstanding;
`ifdef WR_DATA_BRESP_ERR_EN
  logic [15:0] err_cnt;
  logic        err_flag;
`endif

  wr_data_fsm #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .outstanding (outstanding)
`ifdef WR_DATA_BRESP_ERR_EN
    ,
    .err_cnt     (err_cnt),
    .err_flag    (err_flag)
`endif
  );

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy = 0;
  logic [31:0] m_strb_q[$];
  int          m_out = 0, m_err = 0, m_hs_total = 0;
  bit          m_eflag = 0;

  function automatic void m_start(input logic [127:0] h);
    int len, off, nb, g;
    logic [31:0] a, st;
    logic [3:0]  s;
    len = (h[9:0] == 10'd0) ? 1024 : int'(h[9:0]);
    a   = h[29] ? h[127:96] : h[95:64];
    off = int'(a[4:2]);
    nb  = (off + len + LANES - 1) / LANES;
    m_strb_q.delete();
    for (int b = 0; b < nb; b++) begin
      st = '0;
      for (int i = 0; i < LANES; i++) begin
        g = b * LANES + i;
        s = 4'h0;
        if (g >= off && g < off + len) begin
          if (g == off)                        s = h[35:32];
          else if (g == off + len - 1 && len > 1) s = h[39:36];
          else                                 s = 4'hF;
        end
        st[i*4 +: 4] = s;
      end
      m_strb_q.push_back(st);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit whs, lhs, bhs, acc;
    if (!rst_n) begin
      m_busy = 0; m_strb_q.delete(); m_out = 0; m_err = 0; m_eflag = 0;
    end else begin
      whs = m_busy && bus.pld_valid && bus.wready;
      lhs = whs && (m_strb_q.size() == 1);
      bhs = bus.bvalid && (m_out != 0);
      acc = !m_busy && bus.hdr_wren && (m_out != MAXO);
      if (bhs && bus.bresp != 2'b00) begin
        if (m_err < 65535) m_err++;
        m_eflag = 1;
      end
      if (whs) begin
        void'(m_strb_q.pop_front());
        m_hs_total++;
      end
      if (lhs) m_busy = 0;
      m_out = m_out + (lhs ? 1 : 0) - (bhs ? 1 : 0);
      if (acc) begin
        m_start(bus.hdr_data);
        m_busy = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int dut_hs = 0;
  always @(negedge clk) begin : compare
    logic [31:0] es;
    if (rst_n) begin
      es = '0;
      if (m_busy && m_strb_q.size() > 0) es = m_strb_q[0];
      chk("wvalid",      bus.wvalid,    m_busy && bus.pld_valid);
      chk("pld_ready",   bus.pld_ready, m_busy && bus.wready);
      chk("wdata",       bus.wdata,     m_busy ? bus.pld_data : '0);
      chk("wstrb",       bus.wstrb,     es);
      chk("wlast",       bus.wlast,     m_busy && m_strb_q.size() == 1);
      chk("hdr_busy",    bus.hdr_busy,  m_busy || m_out == MAXO);
      chk("bready",      bus.bready,    m_out != 0);
      chk("outstanding", outstanding,   m_out);
`ifdef WR_DATA_BRESP_ERR_EN
      chk("err_cnt",     err_cnt,       m_err);
      chk("err_flag",    err_flag,      m_eflag);
`endif
      if (bus.wvalid && bus.wready) dut_hs++;
    end
  end

  // ---------------- input drivers ----------------
  int         v_pct = 100, r_pct = 100, b_pct = 0;
  logic       b_man = 0;
  logic [1:0] bresp_man = 2'b00;
  bit         pld_hs = 0;

  always @(negedge clk) pld_hs = bus.pld_valid && bus.pld_ready;

  always @(posedge clk) begin
    #2;
    // payload source never retracts a beat it has offered
    if (!bus.pld_valid || pld_hs) begin
      bus.pld_valid = ($urandom_range(99) < v_pct);
      for (int k = 0; k < LANES; k++) bus.pld_data[k*32 +: 32] = $urandom();
    end
    bus.wready = ($urandom_range(99) < r_pct);
    if (b_pct > 0) begin
      bus.bvalid = ($urandom_range(99) < b_pct);
      bus.bresp  = 2'($urandom_range(3));
    end else begin
      bus.bvalid = b_man;
      bus.bresp  = bresp_man;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_hdr(input bit fmt4, input logic [9:0] len,
                                          input logic [31:0] addr,
                                          input logic [3:0] fbe, input logic [3:0] lbe);
    logic [127:0] h;
    h = '0;
    h[9:0]   = len;
    h[29]    = fmt4;
    h[35:32] = fbe;
    h[39:36] = lbe;
    // the unused address word carries garbage so the wrong selection shows up
    if (fmt4) begin h[127:96] = addr; h[95:64]  = $urandom(); end
    else      begin h[95:64]  = addr; h[127:96] = $urandom(); end
    return h;
  endfunction

  task automatic send_hdr(input logic [127:0] h);
    int n = 0;
    while (bus.hdr_busy && n < 3000) begin tick(); n++; end
    chk("hdr_wait_timeout", bus.hdr_busy, 1'b0);
    bus.hdr_wren = 1'b1;
    bus.hdr_data = h;
    tick();
    bus.hdr_wren = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin tick(); n++; end
    chk("burst_timeout", m_busy, 1'b0);
  endtask

  task automatic drain_b();
    int n = 0;
    while (m_out != 0 && n < 100) begin b_man = 1'b1; tick(); n++; end
    b_man = 1'b0;
    tick();
    chk("drain", outstanding, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random scenarios ----------------
  initial begin : main
    int hs0;
    int n;
    bus.hdr_wren = 0; bus.hdr_data = '0; bus.pld_valid = 0; bus.pld_data = '0;
    bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;

    #3;
    chk("rst_hdr_busy",    bus.hdr_busy,  0);
    chk("rst_wvalid",      bus.wvalid,    0);
    chk("rst_pld_ready",   bus.pld_ready, 0);
    chk("rst_wlast",       bus.wlast,     0);
    chk("rst_wstrb",       bus.wstrb,     0);
    chk("rst_bready",      bus.bready,    0);
    chk("rst_outstanding", outstanding,   0);
    #20 rst_n = 1'b1;
    tick(); tick();

    // single DW, off=3, first_be=6
    send_hdr(mk_hdr(0, 10'd1, 32'h0000_000C, 4'h6, 4'h0));
    @(negedge clk);
    chk("t1_wstrb", bus.wstrb, 32'h0000_6000);
    chk("t1_wlast", bus.wlast, 1);
    tick();
    chk("t1_outstanding", outstanding, 1);
    chk("t1_idle", bus.hdr_busy, 0);
    drain_b();

    // len=10 off=6 spans two beats
    send_hdr(mk_hdr(0, 10'd10, 32'h0000_0018, 4'hC, 4'h3));
    @(negedge clk);
    chk("t2_beat0_wstrb", bus.wstrb, 32'hFC00_0000);
    chk("t2_beat0_wlast", bus.wlast, 0);
    tick();
    @(negedge clk);
    chk("t2_beat1_wstrb", bus.wstrb, 32'h3FFF_FFFF);
    chk("t2_beat1_wlast", bus.wlast, 1);
    wait_idle(10);
    drain_b();

    // 1024 DW burst with stalls on both sides
    v_pct = 85; r_pct = 60;
    hs0 = dut_hs;
    send_hdr(mk_hdr(1, 10'd0, 32'h0000_1000, 4'hF, 4'hF));
    wait_idle(2000);
    chk("t3_beats", dut_hs - hs0, 128);
    v_pct = 100; r_pct = 100;
    drain_b();

    // fill the outstanding limit
    for (int k = 0; k < 8; k++) begin
      send_hdr(mk_hdr(k[0], 10'd1, $urandom() & 32'hFFFF_FFFC, 4'hF, 4'h0));
      wait_idle(20);
    end
    tick();
    chk("t4_outstanding_full", outstanding, 8);
    chk("t4_hdr_busy_full", bus.hdr_busy, 1);
    bus.hdr_wren = 1'b1;
    bus.hdr_data = mk_hdr(0, 10'd1, 32'h0, 4'hF, 4'h0);
    tick();
    bus.hdr_wren = 1'b0;
    chk("t4_ninth_ignored", bus.pld_ready, 0);
    chk("t4_outstanding_hold", outstanding, 8);
    b_man = 1'b1;
    tick();
    b_man = 1'b0;
    chk("t4_after_b", outstanding, 7);
    send_hdr(mk_hdr(0, 10'd1, 32'h4, 4'hF, 4'h0));
    b_man = 1'b1;
    tick();
    b_man = 1'b0;
    chk("t4_simul_unchanged", outstanding, 7);
    chk("t4_back_idle", bus.hdr_busy, 0);

`ifdef WR_DATA_BRESP_ERR_EN
    b_man = 1'b1; bresp_man = 2'b00; tick();
    bresp_man = 2'b10; tick();
    bresp_man = 2'b11; tick();
    b_man = 1'b0; bresp_man = 2'b00;
    chk("err_cnt_literal", err_cnt, 2);
    chk("err_flag_literal", err_flag, 1);
    chk("err_outstanding", outstanding, 4);
`endif

    // reset in the middle of a 4-beat burst with responses still pending
    send_hdr(mk_hdr(0, 10'd32, 32'h0, 4'hF, 4'hF));
    hs0 = m_hs_total;
    n = 0;
    while (m_hs_total - hs0 < 2 && n < 20) begin tick(); n++; end
    chk("t5_two_beats", m_hs_total - hs0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_wvalid",      bus.wvalid,    0);
    chk("t5_pld_ready",   bus.pld_ready, 0);
    chk("t5_wlast",       bus.wlast,     0);
    chk("t5_hdr_busy",    bus.hdr_busy,  0);
    chk("t5_outstanding", outstanding,   0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_hdr(mk_hdr(1, 10'd2, 32'h0000_0008, 4'h1, 4'h8));
    chk("t5_reaccept", bus.pld_ready, 1);
    wait_idle(10);
    chk("t5_outstanding_after", outstanding, 1);
    drain_b();

    // random traffic
    v_pct = 70; r_pct = 70; b_pct = 30;
    for (int k = 0; k < 40; k++) begin
      logic [9:0] len;
      case ($urandom_range(3))
        0, 1:    len = 10'($urandom_range(1, 20));
        2:       len = 10'($urandom_range(1, 1023));
        default: len = 10'($urandom_range(0, 3));
      endcase
      send_hdr(mk_hdr(1'($urandom_range(1)), len, $urandom(),
                      4'($urandom_range(15)), 4'($urandom_range(15))));
    end
    wait_idle(3000);
    b_pct = 0;
    tick();
    drain_b();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
